// File: rtl/bnn_conv_seq_if.sv
// -----------------------------------------------------------------------------
// bnn_conv_seq_if
// Bundles the control, weight-load, datapath and result signals between the
// BNN convolution sequencer and its environment. The sequencer connects
// through the slave modport; the controlling side uses the master modport.
//
// Signals:
//   start, keep_w            - window start request; keep_w reuses weights
//   wt_valid/wt_data/wt_ready - weight row stream (valid/ready)
//   w_en, w_input            - weight shift strobe and row to the datapath
//   opcode                   - datapath opcode {acc, row[2:0], clear}
//   popcnt_add               - datapath accumulator value (signed)
//   res_valid/res_data/res_ready - result handshake
//   busy                     - sequencer not idle
// Parameter RES_W must match the RES_W of the connected sequencer.
// -----------------------------------------------------------------------------
interface bnn_conv_seq_if #(
  parameter int RES_W = 7
);
  logic                    start;
  logic                    keep_w;
  logic                    wt_valid;
  logic [6:0]              wt_data;
  logic                    wt_ready;
  logic                    w_en;
  logic [6:0]              w_input;
  logic [4:0]              opcode;
  logic signed [6:0]       popcnt_add;
  logic                    res_valid;
  logic signed [RES_W-1:0] res_data;
  logic                    res_ready;
  logic                    busy;

  modport master (
    output start, keep_w, wt_valid, wt_data, popcnt_add, res_ready,
    input  wt_ready, w_en, w_input, opcode, res_valid, res_data, busy
  );

  modport slave (
    input  start, keep_w, wt_valid, wt_data, popcnt_add, res_ready,
    output wt_ready, w_en, w_input, opcode, res_valid, res_data, busy
  );
endinterface

// File: rtl/bnn_conv_seq.sv
// -----------------------------------------------------------------------------
// bnn_conv_seq
// Sequencer for one binary-convolution kernel window on an external
// XNOR-popcount datapath. Optionally loads 7 weight rows, clears the
// accumulator, accumulates rows 0..6, waits one cycle for the accumulator
// to settle, captures the result and holds it until consumed.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - bnn_conv_seq_if.slave (start/keep_w, weight stream, datapath
//          strobes/opcode, accumulator input, result handshake, busy)
//
// Configuration:
//   BNN_SEQ_BIPOLAR_EN - when defined, the captured result is the bipolar
//                        dot product 2*popcnt_add - 42 (7 rows x 6 bits);
//                        otherwise popcnt_add is captured unmodified.
//                        Timing is identical in both builds.
// -----------------------------------------------------------------------------
module bnn_conv_seq #(
  parameter int N_ROWS = 7,
  parameter int RES_W  = 7
) (
  input  logic            clk,
  input  logic            rst,
  bnn_conv_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_ACC,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [2:0] LAST_ROW = 3'(N_ROWS - 1);

  state_t                  state, state_next;
  logic [2:0]              cnt, cnt_next;   // rows accepted in LOAD, row index in ACC
  logic signed [RES_W-1:0] res_calc;
  logic signed [RES_W-1:0] res_q;

  // Value latched at the end of WAIT.
`ifdef BNN_SEQ_BIPOLAR_EN
  logic signed [8:0] pop_ext;
  always_comb begin
    pop_ext  = 9'(bus.popcnt_add);
    res_calc = RES_W'((pop_ext <<< 1) - 9'sd42);
  end
`else
  always_comb begin
    res_calc = RES_W'(bus.popcnt_add);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      res_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == S_WAIT) res_q <= res_calc;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bus.wt_ready = 1'b0;
    bus.w_en     = 1'b0;
    bus.w_input  = 7'd0;
    bus.opcode   = 5'd0;

    unique case (state)
      S_IDLE: begin
        cnt_next = 3'd0;
        if (bus.start) state_next = bus.keep_w ? S_CLR : S_LOAD;
      end

      // Rows stream into the datapath shift register, which shifts upward:
      // the first accepted row ends up as row 6, the last as row 0.
      S_LOAD: begin
        bus.wt_ready = 1'b1;
        if (bus.wt_valid) begin
          bus.w_en    = 1'b1;
          bus.w_input = bus.wt_data;
          if (cnt == LAST_ROW) begin
            cnt_next   = 3'd0;
            state_next = S_CLR;
          end else begin
            cnt_next = cnt + 3'd1;
          end
        end
      end

      S_CLR: begin
        bus.opcode = 5'h01;
        cnt_next   = 3'd0;
        state_next = S_ACC;
      end

      S_ACC: begin
        bus.opcode = {1'b1, cnt, 1'b0};
        if (cnt == LAST_ROW) begin
          cnt_next   = 3'd0;
          state_next = S_WAIT;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end

      // The last accumulate lands at the end of the final ACC cycle, so the
      // accumulator is valid throughout WAIT.
      S_WAIT: state_next = S_OUT;

      S_OUT: if (bus.res_ready) state_next = S_IDLE;

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.res_valid = (state == S_OUT);
  assign bus.res_data  = res_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: doc/bnn_conv_seq.md
BNN_CONV_SEQ -- requirements
Module: bnn_conv_seq

Interface
REQ-001 SHALL have parameter N_ROWS, default 7: weight rows per kernel window; fixed at 7 by the downstream XNOR-popcount datapath.
REQ-002 SHALL have parameter RES_W, default 7: width of the signed result.
REQ-003 SHALL use clock clk and reset rst; reset is synchronous and active-high.
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one window computation; sampled in IDLE only
- keep_w  in  1  sampled with start; 1 = skip weight load and reuse the resident weights
- wt_valid  in  1  weight row offered
- wt_data  in  7  weight row bits
- wt_ready  out  1  weight row accepted when high with wt_valid
- w_en  out  1  weight shift enable to the datapath
- w_input  out  7  weight row to the datapath
- opcode  out  5  datapath opcode: [0] accumulator clear, [3:1] row select, [4] accumulate
- popcnt_add  in  7 signed  datapath accumulator
- res_valid  out  1  result available
- res_data  out  RES_W signed  result
- res_ready  in  1  result consumed when high with res_valid
- busy  out  1  high in every state except IDLE

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, CLR, ACC, WAIT and OUT.
REQ-006 IDLE: on start=1, SHALL go to CLR if keep_w=1, else to LOAD; with start=0 SHALL stay in IDLE.
REQ-007 LOAD: wt_ready SHALL be 1; each wt_valid&wt_ready cycle SHALL drive w_en=1 and w_input=wt_data in the same cycle.
REQ-008 LOAD SHALL go to CLR after exactly 7 accepted rows, counted by a 3-bit counter; stalls on wt_valid=0 are allowed and unbounded.
REQ-009 Row order: the first accepted row SHALL become datapath row 6 and the last row 0, because the datapath shift register shifts upward.
REQ-010 Outside LOAD, wt_ready, w_en and w_input SHALL be 0; wt_valid outside LOAD SHALL be ignored.
REQ-011 CLR SHALL last 1 cycle with opcode=5'h01.
REQ-012 ACC SHALL last 7 cycles with opcode={1'b1,row[2:0],1'b0} for row=0..6 in order (5'h10, 5'h12, ... 5'h1C).
REQ-013 WAIT SHALL last 1 cycle with opcode=0; at the end of WAIT, popcnt_add SHALL be captured into res_data.
REQ-014 In all states except CLR and ACC, opcode SHALL be 0.
REQ-015 OUT: res_valid SHALL be 1 and res_data SHALL be held stable; when res_ready=1, SHALL return to IDLE.
REQ-016 With res_ready held at 1, OUT SHALL last exactly 1 cycle.
REQ-017 Latency with keep_w=1: start sampled at edge t -> CLR in cycle t+1, ACC in cycles t+2..t+8, WAIT in t+9, res_valid=1 from t+10.
REQ-018 Latency with keep_w=0: the same as REQ-017 plus the LOAD cycles.
REQ-019 start SHALL be ignored in every state except IDLE, including the OUT handshake cycle; no queuing.
REQ-020 keep_w=1 with no prior load SHALL be legal and SHALL use the datapath's reset weights (zero).

Reset
REQ-021 On rst, the FSM SHALL enter IDLE and the row counter SHALL be 0.
REQ-022 On rst, outputs SHALL be: wt_ready=0, w_en=0, w_input=0, opcode=0, res_valid=0, res_data=0, busy=0.
REQ-023 rst asserted mid-LOAD, ACC or OUT SHALL abort the operation with no further w_en or opcode pulses and discard any pending result.

Configuration
REQ-024 Macro BNN_SEQ_BIPOLAR_EN, when defined, SHALL make the captured value res_data = 2*popcnt_add - 42 (bipolar dot product over 7 rows x 6 bits), signed, range -42..+42.
REQ-025 Without BNN_SEQ_BIPOLAR_EN, res_data SHALL equal popcnt_add unmodified (range 0..42).
REQ-026 The macro SHALL NOT change FSM timing or latency.

Verification
REQ-027 keep_w=1, start pulse at cycle 0 -> opcode sequence 01,10,12,14,16,18,1A,1C,00 in cycles 1-9; res_valid=1 at cycle 10.
REQ-028 keep_w=0, rows 0x01..0x07 offered back-to-back -> w_en high for 7 consecutive cycles, w_input=01..07 in order, CLR in the following cycle.
REQ-029 Datapath with image all ones and weights all 7'h7F -> res_data=42 with and without BNN_SEQ_BIPOLAR_EN; with weights all 0 -> 0 without the macro, -42 with it.
REQ-030 res_ready=0 for 5 cycles in OUT -> res_valid and res_data stable; start pulsed during OUT is ignored; IDLE is entered 1 cycle after res_ready=1.
REQ-031 rst at the 4th ACC cycle -> next cycle opcode=0, busy=0, res_valid=0; a fresh start then runs the full sequence of REQ-027.
REQ-032 LOAD with wt_valid toggling 1,0,0,1,... -> exactly 7 w_en pulses, only on handshake cycles, and the row counter does not advance on stall cycles.
